vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 76 +++++++
 tb/tb_vram_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM shared by video reads and CPU reads/writes; one access per cycle, results one cycle after grant.
// Video has priority, but a CPU kept waiting STARVE cycles preempts it; the refused video read is dropped and counted.
module vram_arbiter #(
  parameter int AW        = 14,
  parameter int DW        = 8,
  parameter int STARVE    = 4,
  parameter     INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vreq,
  input  logic [AW-1:0] va,
  output logic [DW-1:0] vdout,
  output logic          vvalid,
  output logic          vdrop,
  input  logic          creq,
  input  logic          cwe,
  input  logic [AW-1:0] ca,
  input  logic [DW-1:0] cdin,
  output logic [DW-1:0] cdout,
  output logic          cack,
  output logic          cwait,
  output logic [15:0]   dropcnt
);

  localparam logic [3:0] STARVE_L = 4'(STARVE);

  logic [DW-1:0] mem [0:(2**AW)-1];
  logic [3:0]    starve_cnt;
  logic          creq_live;
  logic          vgrant;
  logic          cgrant;
  logic          vrefuse;

  // creq seen alongside its own cack belongs to the completed access, not a new one.
  always_comb begin
    creq_live = creq && !cack;
    vgrant    = !rst && vreq && (starve_cnt < STARVE_L);
    cgrant    = !rst && !vgrant && creq_live;
    vrefuse   = !rst && vreq && !vgrant;
    cwait     = creq_live && !cgrant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vvalid     <= 1'b0;
      vdrop      <= 1'b0;
      cack       <= 1'b0;
      vdout      <= '0;
      cdout      <= '0;
      dropcnt    <= '0;
      starve_cnt <= '0;
    end else begin
      vvalid <= vgrant;
      cack   <= cgrant;
      vdrop  <= vrefuse;
      if (vgrant)
        vdout <= mem[va];
      if (cgrant && !cwe)
        cdout <= mem[ca];
      if (vrefuse && (dropcnt != 16'hFFFF))
        dropcnt <= dropcnt + 16'd1;
      if (cgrant || !creq_live)
        starve_cnt <= '0;
      else
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Write is gated by cgrant, which is already forced low while rst is high.
  always_ff @(posedge clk) begin
    if (cgrant && cwe)
      mem[ca] <= cdin;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter against a transaction-level model, plus a small AW=4/DW=16 build.
module tb_vram_arbiter;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int STARVE = 4;
  localparam int TOP = (1 << AW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, vreq = 1'b0, creq = 1'b0, cwe = 1'b0;
  logic [AW-1:0] va = '0, ca = '0;
  logic [DW-1:0] cdin = '0, vdout, cdout;
  logic vvalid, vdrop, cack, cwait;
  logic [15:0] dropcnt;

  logic s_rst = 1'b1, s_vreq = 1'b0, s_creq = 1'b0, s_cwe = 1'b0;
  logic [3:0] s_va = '0, s_ca = '0;
  logic [15:0] s_cdin = '0, s_vdout, s_cdout, s_dropcnt;
  logic s_vvalid, s_vdrop, s_cack, s_cwait;

  vram_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) u_dut (
    .clk(clk), .rst(rst), .vreq(vreq), .va(va), .vdout(vdout), .vvalid(vvalid),
    .vdrop(vdrop), .creq(creq), .cwe(cwe), .ca(ca), .cdin(cdin), .cdout(cdout),
    .cack(cack), .cwait(cwait), .dropcnt(dropcnt)
  );

  vram_arbiter #(.AW(4), .DW(16), .STARVE(4)) u_small (
    .clk(clk), .rst(s_rst), .vreq(s_vreq), .va(s_va), .vdout(s_vdout), .vvalid(s_vvalid),
    .vdrop(s_vdrop), .creq(s_creq), .cwe(s_cwe), .ca(s_ca), .cdin(s_cdin), .cdout(s_cdout),
    .cack(s_cack), .cwait(s_cwait), .dropcnt(s_dropcnt)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: memory contents, starvation count, and outputs expected after the next edge.
  logic [DW-1:0] ref_mem [int];
  int starve = 0;
  int e_drop = 0;
  bit e_vvalid = 0, e_cack = 0, e_vdrop = 0;
  logic [DW-1:0] e_vdout = '0, e_cdout = '0;
  bit seen_cwait;

  function automatic int pick();
    int r;
    r = $urandom_range(0, 16);
    return (r == 16) ? TOP : r;
  endfunction

  task automatic tick(input bit r, input bit vq, input int vad, input bit cq,
                      input bit we, input int cad, input int cd);
    bit live, vwin, cwin;
    rst = r; vreq = vq; va = AW'(vad); creq = cq; cwe = we; ca = AW'(cad); cdin = DW'(cd);
    #1;
    seen_cwait = cwait;
    if (r) begin
      chk("rst_vvalid", 32'(vvalid), 0);
      chk("rst_cack", 32'(cack), 0);
      chk("rst_vdrop", 32'(vdrop), 0);
      chk("rst_vdout", 32'(vdout), 0);
      chk("rst_cdout", 32'(cdout), 0);
      chk("rst_dropcnt", 32'(dropcnt), 0);
      chk("rst_cwait", 32'(cwait), 32'(cq));
      starve = 0; e_drop = 0; e_vvalid = 0; e_cack = 0; e_vdrop = 0;
      e_vdout = '0; e_cdout = '0;
    end else begin
      live = cq && !e_cack;
      vwin = vq && (starve < STARVE);
      cwin = !vwin && live;
      chk("cwait", 32'(cwait), 32'(live && !cwin));
      e_vvalid = vwin;
      e_cack = cwin;
      e_vdrop = vq && !vwin;
      if (vwin) e_vdout = ref_mem[vad];
      if (cwin) begin
        if (we) ref_mem[cad] = DW'(cd);
        else e_cdout = ref_mem[cad];
      end
      if (e_vdrop && e_drop < 65535) e_drop++;
      starve = (cwin || !live) ? 0 : starve + 1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("vvalid", 32'(vvalid), 32'(e_vvalid));
    chk("cack", 32'(cack), 32'(e_cack));
    chk("vdrop", 32'(vdrop), 32'(e_vdrop));
    chk("vdout", 32'(vdout), 32'(e_vdout));
    chk("cdout", 32'(cdout), 32'(e_cdout));
    chk("dropcnt", 32'(dropcnt), 32'(e_drop));
  endtask

  // CPU access held until cack; returns cycles taken and cycles cwait was seen high.
  task automatic cpu_op(input bit we, input int a, input int d, input bit vq,
                        output int lat, output int waits);
    lat = 0;
    waits = 0;
    for (int i = 0; i < 40; i++) begin
      tick(0, vq, i % 8, 1, we, a, d);
      lat++;
      if (seen_cwait) waits++;
      if (cack) break;
    end
    chk("cpu_ack_seen", 32'(cack), 1);
  endtask

  task automatic s_op(input bit we, input int a, input int d, output logic [15:0] q);
    s_creq = 1'b1; s_cwe = we; s_ca = 4'(a); s_cdin = 16'(d);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (s_cack) break;
    end
    chk("small_cack", 32'(s_cack), 1);
    q = s_cdout;
    s_creq = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int lat, waits;
    bit busy, pwe;
    int pa, pd;
    logic [15:0] q;

    repeat (2) @(negedge clk);
    s_rst = 1'b0;
    s_op(1, 0, 16'h1234, q);
    s_op(1, 15, 16'hABCD, q);
    s_op(0, 0, 0, q);
    chk("small_rd_addr0", 32'(q), 32'h1234);
    s_op(0, 15, 0, q);
    chk("small_rd_addr15", 32'(q), 32'hABCD);
    chk("small_vvalid", 32'(s_vvalid), 0);
    chk("small_vdout", 32'(s_vdout), 0);
    chk("small_vdrop", 32'(s_vdrop), 0);
    chk("small_cwait", 32'(s_cwait), 0);
    chk("small_dropcnt", 32'(s_dropcnt), 0);

    tick(1, 0, 0, 1, 0, 0, 0);
    tick(1, 0, 0, 1, 0, 0, 0);

    for (int a = 0; a < 16; a++) cpu_op(1, a, (a * 37 + 5) & 255, 0, lat, waits);
    cpu_op(1, TOP, 8'h5C, 0, lat, waits);
    tick(0, 0, 0, 0, 0, 0, 0);

    cpu_op(1, 14'h1800, 8'hA5, 0, lat, waits);
    chk("wr_latency", 32'(lat), 1);
    tick(0, 0, 0, 0, 0, 0, 0);
    cpu_op(0, 14'h1800, 0, 0, lat, waits);
    chk("rd_latency", 32'(lat), 1);
    chk("rd_1800", 32'(cdout), 32'hA5);
    tick(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      tick(0, 1, i, 0, 0, 0, 0);
      chk("video_burst_valid", 32'(vvalid), 1);
    end
    tick(0, 0, 0, 0, 0, 0, 0);

    cpu_op(0, 3, 0, 1, lat, waits);
    chk("starve_grant_cycle", 32'(lat), 5);
    chk("starve_cwait_cycles", 32'(waits), 4);
    chk("starve_vdrop", 32'(vdrop), 1);
    chk("starve_dropcnt", 32'(dropcnt), 1);
    tick(0, 0, 0, 0, 0, 0, 0);

    busy = 0; pwe = 0; pa = 0; pd = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!busy && $urandom_range(0, 3) == 0) begin
        busy = 1;
        pwe = 1'($urandom_range(0, 1));
        pa = pick();
        pd = $urandom_range(0, 255);
      end
      tick(0, $urandom_range(0, 2) != 0, pick(), busy, pwe, pa, pd);
      if (busy && cack) busy = 0;
    end

    tick(0, 1, 1, 1, 1, 5, 8'h77);
    tick(0, 1, 2, 1, 1, 5, 8'h77);
    tick(1, 1, 3, 1, 1, 5, 8'h77);
    tick(1, 1, 3, 1, 1, 5, 8'h77);
    tick(0, 1, 4, 1, 0, 6, 0);
    chk("post_rst_first_vvalid", 32'(vvalid), 1);
    chk("post_rst_vdout", 32'(vdout), 32'(ref_mem[4]));
    for (int a = 0; a <= 16; a++) tick(0, 1, (a == 16) ? TOP : a, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);

    force u_dut.dropcnt = 16'hFFFC;
    #1;
    release u_dut.dropcnt;
    e_drop = 16'hFFFC;
    for (int k = 0; k < 6; k++) cpu_op(0, k, 0, 1, lat, waits);
    chk("drop_saturate", 32'(dropcnt), 32'hFFFF);
    tick(0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
